// File: rtl/ask4_sym_rcv.sv
// 4-ASK receive symbol recovery: phase pick, tracked-reference slicer, block statistics.
// Define SYM_RCV_ERR_AVG_EN to build the signed error-mean (DC bias) monitor.
module ask4_sym_rcv #(
    parameter int unsigned        ACC_LOG2 = 18,
    parameter logic signed [17:0] REF_INIT = 18'sd32768
) (
    input  logic               sys_clk,
    input  logic               reset,
    input  logic               sam_clk_en,
    input  logic               sym_clk_en,
    input  logic signed [17:0] dv_in,
    input  logic [1:0]         phase_sel,
    output logic [1:0]         sym_out,
    output logic               sym_valid,
    output logic signed [17:0] error,
    output logic signed [17:0] ref_lvl,
    output logic [35:0]        err_sq_avg,
    output logic signed [17:0] err_avg,
    output logic               stats_valid
);

    localparam int unsigned MAG_W = 18 + ACC_LOG2;
    localparam int unsigned SQ_W  = 36 + ACC_LOG2;
    localparam logic signed [17:0] DV_MIN = {1'b1, {17{1'b0}}};
    localparam logic signed [17:0] DV_MAX = {1'b0, {17{1'b1}}};

    typedef enum logic [1:0] {
        SYM_M3 = 2'b00,
        SYM_M1 = 2'b01,
        SYM_P1 = 2'b10,
        SYM_P3 = 2'b11
    } sym_e;

    logic signed [17:0]  d1_q, d2_q, d3_q;
    logic signed [17:0]  dec_var_q;
    logic                s1_q;
    sym_e                sym_q;
    logic                sym_valid_q;
    logic signed [17:0]  err_q;
    logic signed [17:0]  ref_q;
    logic [35:0]         sq_avg_q;
    logic                stats_valid_q;
    logic [MAG_W-1:0]    mag_acc_q;
    logic [SQ_W-1:0]     sq_acc_q;
    logic [ACC_LOG2-1:0] sym_cnt_q;

    logic signed [17:0]  tap_sel;
    sym_e                sym_d;
    logic signed [19:0]  dv20, r20, half20, lvl20, diff20;
    logic signed [17:0]  err_d;
    logic [17:0]         mag_d;
    logic [35:0]         err_ext, err_sq_d;
    logic [MAG_W-1:0]    mag_sum;
    logic [SQ_W-1:0]     sq_sum;
    logic                block_end;

    // Pre-shift tap values: the sample being shifted in this cycle is tap 0.
    always_comb begin
        // NOTE: default first so every path assigns tap_sel and no latch is inferred.
        tap_sel = dv_in;
        case (phase_sel)
            2'd1:    tap_sel = d1_q;
            2'd2:    tap_sel = d2_q;
            2'd3:    tap_sel = d3_q;
            default: tap_sel = dv_in;
        endcase
    end

    always_comb begin
        dv20   = {{2{dec_var_q[17]}}, dec_var_q};
        r20    = {{2{ref_q[17]}}, ref_q};
        half20 = r20 >>> 1;
        sym_d  = SYM_M3;
        lvl20  = -(r20 + half20);
        if (dv20 >= r20) begin
            sym_d = SYM_P3;
            lvl20 = r20 + half20;
        end else if (dv20 >= 20'sd0) begin
            sym_d = SYM_P1;
            lvl20 = half20;
        end else if (dv20 >= -r20) begin
            sym_d = SYM_M1;
            lvl20 = -half20;
        end
        diff20 = dv20 - lvl20;
        if (diff20 > 20'sd131071) begin
            err_d = DV_MAX;
        end else if (diff20 < -20'sd131072) begin
            err_d = DV_MIN;
        end else begin
            err_d = diff20[17:0];
        end
    end

    // |dv| with the most negative code clipped to full scale.
    always_comb begin
        if (dec_var_q == DV_MIN) begin
            mag_d = 18'(DV_MAX);
        end else if (dec_var_q[17]) begin
            mag_d = 18'(-dec_var_q);
        end else begin
            mag_d = 18'(dec_var_q);
        end
        err_ext   = {{18{err_d[17]}}, err_d};
        err_sq_d  = err_ext * err_ext;
        mag_sum   = mag_acc_q + {{ACC_LOG2{1'b0}}, mag_d};
        sq_sum    = sq_acc_q + {{ACC_LOG2{1'b0}}, err_sq_d};
        block_end = (sym_cnt_q == '1);
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            d1_q          <= '0;
            d2_q          <= '0;
            d3_q          <= '0;
            dec_var_q     <= '0;
            s1_q          <= 1'b0;
            sym_q         <= SYM_M3;
            sym_valid_q   <= 1'b0;
            err_q         <= '0;
            ref_q         <= REF_INIT;
            sq_avg_q      <= '0;
            stats_valid_q <= 1'b0;
            mag_acc_q     <= '0;
            sq_acc_q      <= '0;
            sym_cnt_q     <= '0;
        end else begin
            // NOTE: non-blocking so the delay line shifts and taps read pre-shift values.
            if (sam_clk_en) begin
                d1_q <= dv_in;
                d2_q <= d1_q;
                d3_q <= d2_q;
            end
            if (sym_clk_en) begin
                dec_var_q <= tap_sel;
            end
            s1_q          <= sym_clk_en;
            sym_valid_q   <= s1_q;
            stats_valid_q <= s1_q && block_end;
            if (s1_q) begin
                sym_q     <= sym_d;
                err_q     <= err_d;
                sym_cnt_q <= sym_cnt_q + ACC_LOG2'(1);
                if (block_end) begin
                    ref_q     <= 18'(mag_sum >> ACC_LOG2);
                    sq_avg_q  <= 36'(sq_sum >> ACC_LOG2);
                    mag_acc_q <= '0;
                    sq_acc_q  <= '0;
                end else begin
                    mag_acc_q <= mag_sum;
                    sq_acc_q  <= sq_sum;
                end
            end
        end
    end

`ifdef SYM_RCV_ERR_AVG_EN
    logic signed [MAG_W-1:0] err_acc_q;
    logic signed [MAG_W-1:0] err_sum;
    logic signed [17:0]      err_avg_q;

    assign err_sum = err_acc_q + {{ACC_LOG2{err_d[17]}}, err_d};

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            err_acc_q <= '0;
            err_avg_q <= '0;
        end else if (s1_q) begin
            if (block_end) begin
                err_avg_q <= 18'(err_sum >>> ACC_LOG2);
                err_acc_q <= '0;
            end else begin
                err_acc_q <= err_sum;
            end
        end
    end

    assign err_avg = err_avg_q;
`else
    assign err_avg = '0;
`endif

    assign sym_out     = sym_q;
    assign sym_valid   = sym_valid_q;
    assign error       = err_q;
    assign ref_lvl     = ref_q;
    assign err_sq_avg  = sq_avg_q;
    assign stats_valid = stats_valid_q;

endmodule

// File: tb/tb_ask4_sym_rcv.sv
// Directed bench for ask4_sym_rcv with ACC_LOG2=2 (4-symbol statistics blocks).
module tb_ask4_sym_rcv;

    localparam int ACC_LOG2 = 2;

    logic               sys_clk;
    logic               reset;
    logic               sam_clk_en;
    logic               sym_clk_en;
    logic signed [17:0] dv_in;
    logic [1:0]         phase_sel;
    logic [1:0]         sym_out;
    logic               sym_valid;
    logic signed [17:0] error;
    logic signed [17:0] ref_lvl;
    logic [35:0]        err_sq_avg;
    logic signed [17:0] err_avg;
    logic               stats_valid;

    int errors = 0;
    int checks = 0;

    ask4_sym_rcv #(.ACC_LOG2(ACC_LOG2)) dut (
        .sys_clk    (sys_clk),
        .reset      (reset),
        .sam_clk_en (sam_clk_en),
        .sym_clk_en (sym_clk_en),
        .dv_in      (dv_in),
        .phase_sel  (phase_sel),
        .sym_out    (sym_out),
        .sym_valid  (sym_valid),
        .error      (error),
        .ref_lvl    (ref_lvl),
        .err_sq_avg (err_sq_avg),
        .err_avg    (err_avg),
        .stats_valid(stats_valid)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        sam_clk_en = 1'b0;
        sym_clk_en = 1'b0;
        dv_in      = '0;
        phase_sel  = 2'd0;
        step();
        step();
        reset = 1'b0;
    endtask

    // One symbol through phase 0; returns what was seen after the S1 and S2 edges.
    task automatic send_sym(input logic signed [17:0] dv, output logic early, output logic vld,
                            output logic [1:0] sym, output logic signed [17:0] err,
                            output logic sv);
        dv_in      = dv;
        phase_sel  = 2'd0;
        sam_clk_en = 1'b1;
        sym_clk_en = 1'b1;
        step();
        sam_clk_en = 1'b0;
        sym_clk_en = 1'b0;
        early = sym_valid;
        step();
        vld = sym_valid;
        sym = sym_out;
        err = error;
        sv  = stats_valid;
        step();
    endtask

    task automatic test_reset();
        logic e, v, s;
        logic [1:0] sy;
        logic signed [17:0] er;
        do_reset();
        checks++;
        if (sym_out !== 2'd0 || sym_valid !== 1'b0 || error !== 18'sd0 || stats_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_outs: sym=%0d vld=%0b err=%0d sv=%0b, want all 0", sym_out, sym_valid, error, stats_valid);
        end
        checks++;
        if (ref_lvl !== 18'sd32768) begin
            errors++;
            $display("FAIL reset_ref: got %0d want 32768", ref_lvl);
        end
        checks++;
        if (err_sq_avg !== 36'd0 || err_avg !== 18'sd0) begin
            errors++;
            $display("FAIL reset_stats: sq=%0d avg=%0d want 0 0", err_sq_avg, err_avg);
        end
        for (int i = 0; i < 4; i++) send_sym(18'sd70000, e, v, sy, er, s);
        checks++;
        if (ref_lvl !== 18'sd70000 || err_sq_avg !== 36'd434639104) begin
            errors++;
            $display("FAIL prerst_stats: ref=%0d sq=%0d want 70000 434639104", ref_lvl, err_sq_avg);
        end
        // Symbol in flight when reset is raised for three cycles.
        dv_in      = 18'sd5000;
        sam_clk_en = 1'b1;
        sym_clk_en = 1'b1;
        step();
        sam_clk_en = 1'b0;
        sym_clk_en = 1'b0;
        reset      = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        checks++;
        if (sym_out !== 2'd0 || error !== 18'sd0 || err_sq_avg !== 36'd0 || err_avg !== 18'sd0) begin
            errors++;
            $display("FAIL midrst_outs: sym=%0d err=%0d sq=%0d avg=%0d want 0", sym_out, error, err_sq_avg, err_avg);
        end
        checks++;
        if (ref_lvl !== 18'sd32768) begin
            errors++;
            $display("FAIL midrst_ref: got %0d want 32768", ref_lvl);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (sym_valid !== 1'b0 || stats_valid !== 1'b0) begin
                errors++;
                $display("FAIL midrst_quiet: cycle %0d vld=%0b sv=%0b want 0 0", i, sym_valid, stats_valid);
            end
            step();
        end
    endtask

    task automatic test_boundaries();
        logic signed [17:0] dv_v [4];
        logic [1:0]         sym_v [4];
        logic signed [17:0] err_v [4];
        logic e, v, s;
        logic [1:0] sy;
        logic signed [17:0] er;
        dv_v  = '{18'sd32768, 18'sd0, -18'sd32768, -18'sd32769};
        sym_v = '{2'b11, 2'b10, 2'b01, 2'b00};
        err_v = '{-18'sd16384, -18'sd16384, -18'sd16384, 18'sd16383};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send_sym(dv_v[i], e, v, sy, er, s);
            checks++;
            if (e !== 1'b0 || v !== 1'b1) begin
                errors++;
                $display("FAIL bnd_valid[%0d]: early=%0b vld=%0b want 0 1", i, e, v);
            end
            checks++;
            if (sy !== sym_v[i] || er !== err_v[i]) begin
                errors++;
                $display("FAIL bnd_slice[%0d]: sym=%0d err=%0d want %0d %0d", i, sy, er, sym_v[i], err_v[i]);
            end
        end
    endtask

    task automatic test_delay_line();
        logic signed [17:0] exp_e;
        do_reset();
        phase_sel = 2'd2;
        for (int n = 1; n <= 12; n++) begin
            dv_in      = 18'(n);
            sam_clk_en = 1'b1;
            sym_clk_en = (n % 4 == 0);
            step();
            sam_clk_en = 1'b0;
            sym_clk_en = 1'b0;
            if (n % 4 == 0) begin
                checks++;
                if (sym_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL dl_early[%0d]: vld=%0b want 0", n, sym_valid);
                end
                step();
                exp_e = 18'(n - 2 - 16384);
                checks++;
                if (sym_valid !== 1'b1 || sym_out !== 2'b10 || error !== exp_e) begin
                    errors++;
                    $display("FAIL dl_tap2[%0d]: vld=%0b sym=%0d err=%0d want 1 2 %0d", n, sym_valid, sym_out, error, exp_e);
                end
            end else begin
                step();
            end
        end
        // Symbol strobe alone: tap 1 holds 12, dv_in must not shift in.
        dv_in      = 18'sd999;
        phase_sel  = 2'd1;
        sym_clk_en = 1'b1;
        step();
        sym_clk_en = 1'b0;
        step();
        checks++;
        if (sym_out !== 2'b10 || error !== -18'sd16372) begin
            errors++;
            $display("FAIL dl_noshift: sym=%0d err=%0d want 2 -16372", sym_out, error);
        end
        // Block closed on {2,6,10,12}: R=7, tap 2 still 11 -> +3a, level 10.
        phase_sel  = 2'd2;
        sym_clk_en = 1'b1;
        step();
        sym_clk_en = 1'b0;
        step();
        checks++;
        if (sym_out !== 2'b11 || error !== 18'sd1 || ref_lvl !== 18'sd7) begin
            errors++;
            $display("FAIL dl_newref: sym=%0d err=%0d ref=%0d want 3 1 7", sym_out, error, ref_lvl);
        end
    endtask

    task automatic test_ref_update();
        logic signed [17:0] dv_v [4];
        logic [1:0]         sym_v [4];
        logic signed [17:0] err_v [4];
        logic e, v, s;
        logic [1:0] sy;
        logic signed [17:0] er;
        dv_v  = '{18'sd65536, -18'sd65536, 18'sd65536, -18'sd65536};
        sym_v = '{2'b11, 2'b00, 2'b11, 2'b00};
        err_v = '{18'sd16384, -18'sd16384, 18'sd16384, -18'sd16384};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send_sym(dv_v[i], e, v, sy, er, s);
            checks++;
            if (v !== 1'b1 || sy !== sym_v[i] || er !== err_v[i] || s !== (i == 3)) begin
                errors++;
                $display("FAIL ref_sym[%0d]: vld=%0b sym=%0d err=%0d sv=%0b want 1 %0d %0d %0b",
                         i, v, sy, er, s, sym_v[i], err_v[i], (i == 3));
            end
        end
        checks++;
        if (ref_lvl !== 18'sd65536 || err_sq_avg !== 36'd268435456 || err_avg !== 18'sd0) begin
            errors++;
            $display("FAIL ref_stats: ref=%0d sq=%0d avg=%0d want 65536 268435456 0", ref_lvl, err_sq_avg, err_avg);
        end
        send_sym(18'sd40000, e, v, sy, er, s);
        checks++;
        if (sy !== 2'b10 || er !== 18'sd7232 || s !== 1'b0) begin
            errors++;
            $display("FAIL ref_apply: sym=%0d err=%0d sv=%0b want 2 7232 0", sy, er, s);
        end
    endtask

    task automatic test_err_stats();
        logic e, v, s;
        logic [1:0] sy;
        logic signed [17:0] er;
        logic signed [17:0] exp_avg;
`ifdef SYM_RCV_ERR_AVG_EN
        exp_avg = 18'sd1024;
`else
        exp_avg = 18'sd0;
`endif
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send_sym(18'sd50176, e, v, sy, er, s);
            checks++;
            if (sy !== 2'b11 || er !== 18'sd1024) begin
                errors++;
                $display("FAIL est_sym[%0d]: sym=%0d err=%0d want 3 1024", i, sy, er);
            end
        end
        checks++;
        if (err_sq_avg !== 36'd1048576 || err_avg !== exp_avg || ref_lvl !== 18'sd50176) begin
            errors++;
            $display("FAIL est_stats: sq=%0d avg=%0d ref=%0d want 1048576 %0d 50176", err_sq_avg, err_avg, ref_lvl, exp_avg);
        end
    endtask

    task automatic test_saturation();
        logic e, v, s;
        logic [1:0] sy;
        logic signed [17:0] er;
        logic signed [17:0] exp_avg;
`ifdef SYM_RCV_ERR_AVG_EN
        exp_avg = -18'sd81920;
`else
        exp_avg = 18'sd0;
`endif
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send_sym(-18'sd131072, e, v, sy, er, s);
            checks++;
            if (sy !== 2'b00 || er !== -18'sd81920) begin
                errors++;
                $display("FAIL sat_sym[%0d]: sym=%0d err=%0d want 0 -81920", i, sy, er);
            end
        end
        checks++;
        if (ref_lvl !== 18'sd131071 || err_sq_avg !== 36'd6710886400 || err_avg !== exp_avg) begin
            errors++;
            $display("FAIL sat_stats: ref=%0d sq=%0d avg=%0d want 131071 6710886400 %0d", ref_lvl, err_sq_avg, err_avg, exp_avg);
        end
        // R=131071: level -(131071+65535) gives 65534.
        for (int i = 0; i < 2; i++) begin
            send_sym(-18'sd131072, e, v, sy, er, s);
            checks++;
            if (sy !== 2'b00 || er !== 18'sd65534) begin
                errors++;
                $display("FAIL sat_fullref[%0d]: sym=%0d err=%0d want 0 65534", i, sy, er);
            end
        end
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send_sym(-18'sd131072, e, v, sy, er, s);
            checks++;
            if (v !== 1'b1 || s !== (i == 3)) begin
                errors++;
                $display("FAIL sat_partial[%0d]: vld=%0b sv=%0b want 1 %0b", i, v, s, (i == 3));
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        sam_clk_en = 1'b0;
        sym_clk_en = 1'b0;
        dv_in      = '0;
        phase_sel  = 2'd0;
        test_reset();
        test_boundaries();
        test_delay_line();
        test_ref_update();
        test_err_stats();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
